// File: rtl/comparador_serial_id_if.sv
// comparador_serial_id_if: start/operand/result bundle for the serial MSB-first comparator.
interface comparador_serial_id_if #(
    parameter int K  = 4,
    parameter int PW = (K > 1) ? $clog2(K) : 1
);
    logic          start;
    logic [K-1:0]  A;
    logic [K-1:0]  B;
    logic          busy;
    logic          done;
    logic          mayor;
    logic          menor;
    logic          igual;
    logic [PW-1:0] pos;
    modport master (output start, A, B, input busy, done, mayor, menor, igual, pos);
    modport slave  (input start, A, B, output busy, done, mayor, menor, igual, pos);
endinterface

// File: rtl/comparador_serial_id.sv
// comparador_serial_id: serial MSB-first magnitude comparator, one bit per clock.
// Define COMPARADOR_EARLY_EXIT_EN to end the scan on the first differing bit.
module comparador_serial_id #(
    parameter int K = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    comparador_serial_id_if.slave bus
);
    localparam int PW = (K > 1) ? $clog2(K) : 1;
`ifdef COMPARADOR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state_q, state_d;
    logic [K-1:0]  a_q, a_d, b_q, b_d, sh_a, sh_b;
    logic [PW-1:0] idx_q, idx_d, fpos_q, fpos_d, pos_q, pos_d;
    logic          found_q, found_d, fmay_q, fmay_d;
    logic          done_q, done_d, mayor_q, mayor_d, menor_q, menor_d, igual_q, igual_d;
    logic          diff, first, decide;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            found_q <= 1'b0;
            fmay_q  <= 1'b0;
            fpos_q  <= '0;
            done_q  <= 1'b0;
            mayor_q <= 1'b0;
            menor_q <= 1'b0;
            igual_q <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            found_q <= found_d;
            fmay_q  <= fmay_d;
            fpos_q  <= fpos_d;
            done_q  <= done_d;
            mayor_q <= mayor_d;
            menor_q <= menor_d;
            igual_q <= igual_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        sh_a    = a_q >> idx_q;
        sh_b    = b_q >> idx_q;
        diff    = sh_a[0] ^ sh_b[0];
        first   = !found_q && diff;
        decide  = (idx_q == '0) || (EARLY && first);
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        found_d = found_q;
        fmay_d  = fmay_q;
        fpos_d  = fpos_q;
        done_d  = 1'b0;
        mayor_d = mayor_q;
        menor_d = menor_q;
        igual_d = igual_q;
        pos_d   = pos_q;
        if (state_q == IDLE) begin
            if (bus.start) begin
                state_d = SCAN;
                a_d     = bus.A;
                b_d     = bus.B;
                idx_d   = PW'(K - 1);
                found_d = 1'b0;
            end
        end else if (decide) begin
            // A difference seen earlier wins over whatever the last bit says.
            state_d = IDLE;
            done_d  = 1'b1;
            mayor_d = found_q ? fmay_q  : (sh_a[0] & diff);
            menor_d = found_q ? !fmay_q : (sh_b[0] & diff);
            igual_d = !found_q && !diff;
            pos_d   = found_q ? fpos_q : (diff ? idx_q : '0);
        end else begin
            idx_d = idx_q - 1'b1;
            if (first) begin
                found_d = 1'b1;
                fmay_d  = sh_a[0];
                fpos_d  = idx_q;
            end
        end
    end

    assign bus.busy  = (state_q == SCAN);
    assign bus.done  = done_q;
    assign bus.mayor = mayor_q;
    assign bus.menor = menor_q;
    assign bus.igual = igual_q;
    assign bus.pos   = pos_q;
endmodule

// File: doc/comparador_serial_id.md
# comparador_serial_id

Sequential left-to-right (MSB-first) magnitude comparator for two K-bit unsigned operands. It is the counterpart of the combinational right-to-left iterative comparator network. It latches A and B on a start handshake and examines one bit position per clock, from bit K-1 down to bit 0. It reports mayor/menor/igual and the index of the deciding bit, pulsing `done` when the result is valid. It serves datapaths that prefer a small serial comparator with data-dependent latency over a K-cell ripple chain.

## Interface
- `K`, default 4: operand width in bits; legal range K ≥ 1.
- `clk`  input  1  rising-edge clock, single clock domain.
- `reset_n`  input  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `start`  input  1  request to start a comparison; accepted only when `busy`=0.
- `A`  input  K  operand A, sampled on the accepting edge only.
- `B`  input  K  operand B, sampled on the accepting edge only.
- `busy`  output  1  high while a comparison is in progress.
- `done`  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- `mayor`  output  1  A > B.
- `menor`  output  1  A < B.
- `igual`  output  1  A == B.
- `pos`  output  max(1,$clog2(K))  index of the first differing bit, scanning from the MSB; 0 when A == B.

## Operation
- States:
  - IDLE: `busy`=0.
  - SCAN: `busy`=1.
- IDLE → SCAN on an edge with `start`=1:
  - A and B are loaded into internal registers.
  - The index is set to K-1.
  - The found flag is cleared.
- SCAN, per edge, compare `A_r[idx]` with `B_r[idx]`:
  - First difference (found=0 and bits differ): record mayor=A_r[idx], menor=B_r[idx], igual=0, pos=idx; set found=1.
  - Decision edge: occurs when the scan terminates (see Configuration) or when idx==0. On this edge set `done`=1 and return to IDLE.
  - If found=0 when idx==0 was examined and the bits were equal: igual=1, mayor=menor=0, pos=0.
  - Otherwise idx decrements by 1. Once found=1, lower bits do not change the result.
- Exactly one of mayor/menor/igual is high after the first `done`.
- Results hold until the next decision edge. They are not cleared by `start`.
- `start` while `busy`=1 is ignored; the operands are not resampled.
- `start` in the cycle `done`=1 is accepted, since the state is already IDLE. This gives back-to-back operation.
- With K=1, a single SCAN cycle decides.
- Reset (`reset_n`=0 at an edge), including mid-scan:
  - state IDLE;
  - `busy`, `done`, `mayor`, `menor`, `igual` = 0;
  - `pos` = 0;
  - internal operand and index registers cleared.
  - Any comparison in flight is aborted and produces no `done`.

## Timing
- Start accepted at edge N. `busy`=1 from after edge N until after the decision edge.
- Decision edge for a first difference at bit j, with early exit: N + (K - j). Without early exit: always N + K.
- A == B: decision edge at N + K in both configurations.
- `done` is high for exactly the one cycle following the decision edge. `busy` is 0 in that same cycle.
- Result outputs change only on decision edges or reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `COMPARADOR_EARLY_EXIT_EN`
  - Defined: the edge that finds the first differing bit is the decision edge, giving data-dependent latency K - j cycles.
  - Undefined: the scan always runs all K positions. The first difference is still the one reported (same mayor/menor/pos), giving fixed latency of K cycles.
- Functional results are identical in both configurations; only latency and `busy` duration differ.

## Test plan
- K=4, A=1010, B=0110, start at edge N:
  - EN: done after edge N+1, mayor=1, pos=3.
  - Without EN: done after edge N+4, same result.
- K=4, A=B=0101: done after edge N+4 (both configurations), igual=1, mayor=menor=0, pos=0.
- K=4, A=0010, B=0011: menor=1, pos=0, done after edge N+4 in both configurations.
- K=4, A=1100, B=1000 with EN: mayor=1, pos=2, done after N+2. A second start with A=0000, B=1111 applied during `busy` is ignored. A start on the `done` cycle with A=0000, B=1111 gives menor=1, pos=3 one cycle after acceptance.
- K=4, A=0001, B=0000, `reset_n`=0 at edge N+2 mid-scan: all outputs 0 after reset, and no `done` ever appears for that comparison.
- K=1, A=1, B=0: done after edge N+1, mayor=1, pos=0.
